// File: rtl/fb_pkg.sv
// Shared types and default constants for the palette-indexed frame buffer.
package fb_pkg;

  localparam int unsigned PIX_W_DEF   = 5;
  localparam int unsigned KEY_IDX_DEF = 0;
  localparam int unsigned SUB_IDX_DEF = 8;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  typedef enum logic {StIdle, StClear} clr_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Clear engine: walks the draw page once, writing the fill index latched at start.
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH  = 17472,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned PIX_W  = PIX_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_idx,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [PIX_W-1:0]  clr_data
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  clr_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [PIX_W-1:0]  fill_q;

  // Terminal compare is against the real last pixel, not the counter's range.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      fill_q   <= '0;
      clr_busy <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            fill_q   <= clr_idx;
            clr_busy <= 1'b1;
          end
        end
        StClear: begin
          if (cnt_q == LastAddr) begin
            state_q  <= StIdle;
            clr_busy <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = clr_busy;
  assign clr_addr = cnt_q;
  assign clr_data = fill_q;

endmodule

// File: rtl/palette_frame_buffer.sv
// Palette-indexed frame buffer with colour-key write filter and clear engine.
// Optional DOUBLE_BUFFER_EN adds a second page with deferred display swap.
module palette_frame_buffer
  import fb_pkg::*;
#(
  parameter int unsigned  H_RES     = 208,
  parameter int unsigned  V_RES     = 84,
  parameter int unsigned  PIX_W     = PIX_W_DEF,
  parameter int unsigned  KEY_IDX   = KEY_IDX_DEF,
  parameter int unsigned  SUB_IDX   = SUB_IDX_DEF,
  parameter string        INIT_FILE = "",
  localparam int unsigned DEPTH     = H_RES * V_RES,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_skip_key,
  output logic              wr_drop,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_idx,
  output logic              clr_busy,
  input  logic              swap_req,
  output logic              disp_page
);

`ifdef DOUBLE_BUFFER_EN
  localparam int unsigned PAGES = 2;
`else
  localparam int unsigned PAGES = 1;
`endif
  localparam int unsigned   MEM_AW  = $clog2(PAGES * DEPTH);
  localparam logic [ADDR_W:0] DepthX = (ADDR_W + 1)'(DEPTH);

  logic [PIX_W-1:0] mem [PAGES*DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_data;

  fb_clear_engine #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_clear (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr_start (clr_start),
    .clr_idx   (clr_idx),
    .clr_busy  (clr_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data)
  );

  logic draw_page;

`ifdef DOUBLE_BUFFER_EN
  logic swap_pend_q;

  // Swap is held off while a clear runs so the display never shows a half-filled page.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp_page   <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if (swap_pend_q && !clr_busy) begin
      disp_page   <= ~disp_page;
      swap_pend_q <= 1'b0;
    end else if (swap_req) begin
      swap_pend_q <= 1'b1;
    end
  end

  assign draw_page = ~disp_page;
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign disp_page       = 1'b0;
  assign draw_page       = 1'b0;
`endif

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_is_key;
  logic              usr_we;
  logic [PIX_W-1:0]  usr_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;

  always_comb begin
    wr_in_range = {1'b0, wr_addr} < DepthX;
    rd_in_range = {1'b0, rd_addr} < DepthX;
    wr_is_key   = wr_data == PIX_W'(KEY_IDX);
    usr_we      = wr_en && !clr_busy && wr_in_range && !(wr_is_key && wr_skip_key);
    usr_data    = wr_is_key ? PIX_W'(SUB_IDX) : wr_data;
    // Clear engine owns the port while busy; user writes are dropped then anyway.
    mem_we      = clr_we || usr_we;
    mem_waddr   = clr_we ? clr_addr : wr_addr;
    mem_wdata   = clr_we ? clr_data : usr_data;
    wr_idx      = MEM_AW'(mem_waddr) + (draw_page ? MEM_AW'(DEPTH) : '0);
    rd_idx      = MEM_AW'(rd_addr) + (disp_page ? MEM_AW'(DEPTH) : '0);
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[wr_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= mem[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && (clr_busy || !wr_in_range);
    end
  end

endmodule

// File: tb/tb_palette_frame_buffer.sv
// Randomized self-checking bench for palette_frame_buffer against a page-array model.
module tb_palette_frame_buffer;

  localparam int unsigned H_RES   = 208;
  localparam int unsigned V_RES   = 84;
  localparam int unsigned PIX_W   = 5;
  localparam int unsigned KEY_IDX = 0;
  localparam int unsigned SUB_IDX = 8;
  localparam int unsigned DEPTH   = H_RES * V_RES;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic              wr_skip_key = 1'b0;
  logic              wr_drop;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [PIX_W-1:0]  rd_data;
  logic              clr_start = 1'b0;
  logic [PIX_W-1:0]  clr_idx = '0;
  logic              clr_busy;
  logic              swap_req = 1'b0;
  logic              disp_page;

  palette_frame_buffer #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .PIX_W   (PIX_W),
    .KEY_IDX (KEY_IDX),
    .SUB_IDX (SUB_IDX)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_skip_key (wr_skip_key),
    .wr_drop     (wr_drop),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .clr_start   (clr_start),
    .clr_idx     (clr_idx),
    .clr_busy    (clr_busy),
    .swap_req    (swap_req),
    .disp_page   (disp_page)
  );

  always #5 Clk = ~Clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  // model[page][addr]: expected pixel, -1 where the content is not known
  int          model [2][DEPTH];
  bit          busy_m = 1'b0;
  bit          disp_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  function automatic int unsigned draw_pg();
    return DB ? int'(!disp_m) : 0;
  endfunction

  // One clock of traffic: optional write plus a read, checked against the model.
  task automatic op(input bit we, input int unsigned waddr, input int unsigned wdata,
                    input bit skip, input int unsigned raddr, input bit chk_rd,
                    input string tag);
    int          rexp;
    bit          drop_exp;
    int unsigned dp;
    dp       = draw_pg();
    rexp     = (raddr < DEPTH) ? model[disp_m][raddr] : 0;
    drop_exp = we && (busy_m || waddr >= DEPTH);
    wr_en       = we;
    wr_addr     = ADDR_W'(waddr);
    wr_data     = PIX_W'(wdata);
    wr_skip_key = skip;
    rd_addr     = ADDR_W'(raddr);
    cycle();
    wr_en = 1'b0;
    check_eq({tag, ".drop"}, wr_drop, drop_exp);
    if (chk_rd && rexp >= 0) check_eq({tag, ".rd"}, rd_data, rexp);
    if (we && !drop_exp && !(wdata == KEY_IDX && skip))
      model[dp][waddr] = (wdata == KEY_IDX) ? SUB_IDX : wdata;
  endtask

  // Full clear; returns how many sampled cycles clr_busy was high.
  task automatic run_clear(input int unsigned idx, input bit swap, output int unsigned busy_cnt);
    int unsigned dp;
    dp        = draw_pg();
    clr_start = 1'b1;
    clr_idx   = PIX_W'(idx);
    swap_req  = swap;
    cycle();
    clr_start = 1'b0;
    swap_req  = 1'b0;
    busy_m    = 1'b1;
    busy_cnt  = 0;
    while (clr_busy === 1'b1 && busy_cnt < DEPTH + 8) begin
      busy_cnt++;
      if (busy_cnt == 10) begin
        // address 3 is already cleared; a leaked write would leave 5 there
        op(1'b1, 3, 5, 1'b0, 0, 1'b0, "busy_wr");
      end else begin
        swap_req = swap && (busy_cnt == 3);
        cycle();
        swap_req = 1'b0;
      end
    end
    busy_m = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) model[dp][k] = int'(idx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned busy_cnt;
    int unsigned dp;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < int'(DEPTH); k++) model[p][k] = -1;

    repeat (3) cycle();
    check_eq("rst_rd", rd_data, 0);
    check_eq("rst_busy", clr_busy, 0);
    check_eq("rst_drop", wr_drop, 0);
    check_eq("rst_disp", disp_page, 0);
    Reset = 1'b0;

    op(1'b1, 5, 3, 1'b0, 0, 1'b0, "w5");
    op(1'b0, 0, 0, 1'b0, 5, 1'b1, "r5");
    op(1'b1, 5, 6, 1'b0, 5, 1'b1, "rbw");
    op(1'b0, 0, 0, 1'b0, 5, 1'b1, "r5b");

    op(1'b1, 7, KEY_IDX, 1'b0, 0, 1'b0, "key_sub");
    op(1'b0, 0, 0, 1'b0, 7, 1'b1, "r7sub");
    op(1'b1, 7, 4, 1'b0, 0, 1'b0, "w7");
    op(1'b1, 7, KEY_IDX, 1'b1, 7, 1'b1, "key_skip");
    op(1'b0, 0, 0, 1'b0, 7, 1'b1, "r7keep");

    op(1'b1, DEPTH, 7, 1'b0, DEPTH, 1'b1, "oob");
    op(1'b0, 0, 0, 1'b0, DEPTH - 1 + 9, 1'b1, "oob_rd");

    run_clear(2, 1'b0, busy_cnt);
    check_eq("clr_len", busy_cnt, DEPTH);
    op(1'b0, 0, 0, 1'b0, 0, 1'b1, "clr_a0");
    op(1'b0, 0, 0, 1'b0, 8000, 1'b1, "clr_a8000");
    op(1'b0, 0, 0, 1'b0, DEPTH - 1, 1'b1, "clr_last");
    op(1'b0, 0, 0, 1'b0, 3, 1'b1, "clr_a3");

    for (int i = 0; i < 400; i++) begin
      int unsigned wa, wd, ra;
      bit we, sk;
      we = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, (1 << ADDR_W) - 1)
                                         : $urandom_range(0, DEPTH - 1);
      wd = ($urandom_range(0, 3) == 0) ? KEY_IDX : $urandom_range(0, (1 << PIX_W) - 1);
      sk = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 4) == 0) ? wa : $urandom_range(0, DEPTH + 7);
      op(we, wa, wd, sk, ra, 1'b1, "rnd");
    end

    // Reset partway through a clear
    op(1'b1, 50, 13, 1'b0, 0, 1'b0, "pre50");
    op(1'b1, 17000, 11, 1'b0, 0, 1'b0, "pre17000");
    dp        = draw_pg();
    clr_start = 1'b1;
    clr_idx   = PIX_W'(2);
    cycle();
    clr_start = 1'b0;
    busy_m    = 1'b1;
    repeat (99) cycle();
    Reset = 1'b1;
    cycle();
    check_eq("rstclr_busy", clr_busy, 0);
    check_eq("rstclr_rd", rd_data, 0);
    check_eq("rstclr_drop", wr_drop, 0);
    Reset  = 1'b0;
    busy_m = 1'b0;
    disp_m = 1'b0;
    for (int k = 0; k < 99; k++) model[dp][k] = 2;
    model[dp][99] = -1;
    op(1'b0, 0, 0, 1'b0, 50, 1'b1, "rstclr_a50");
    op(1'b0, 0, 0, 1'b0, 17000, 1'b1, "rstclr_a17000");

`ifdef DOUBLE_BUFFER_EN
    op(1'b1, 0, 9, 1'b0, 0, 1'b0, "db_w");
    run_clear(9, 1'b1, busy_cnt);
    check_eq("db_clr_len", busy_cnt, DEPTH);
    check_eq("db_no_swap_yet", disp_page, 0);
    cycle();
    disp_m = 1'b1;
    check_eq("db_swapped", disp_page, 1);
    op(1'b0, 0, 0, 1'b0, 0, 1'b1, "db_rd0");
    repeat (3) cycle();
    check_eq("db_one_swap", disp_page, 1);
`else
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    cycle();
    check_eq("sb_disp", disp_page, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
